time_set_editor: RTL and testbench

- Consumer of auto-repeat button pulses; converts up/down/select pulse streams into an edited HH:MM value for the alarm clock.
- Sits downstream of the per-button edge/auto-repeat detectors and upstream of the timekeeper/alarm registers and the display mux.
- Loads the current time on entry, edits hours then minutes with BCD wrap, and emits a one-cycle commit strobe.

---
 rtl/alarm_clk_pkg.sv | 11 +
 rtl/time_set_editor_if.sv | 26 ++
 rtl/bcd_wrap_counter.sv | 47 ++++
 rtl/time_set_editor.sv | 146 ++++++++++++++
 tb/tb_time_set_editor.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/alarm_clk_pkg.sv
// Shared types and defaults for the alarm-clock time editor.
package alarm_clk_pkg;

    typedef enum logic [1:0] {IDLE, EDIT_HH, EDIT_MM, COMMIT} edit_state_t;

    typedef logic [7:0] bcd2_t;

    localparam int HH_MAX_DEF = 23;
    localparam int MM_MAX_DEF = 59;

endpackage

// File: rtl/time_set_editor_if.sv
// Button pulses and current time in, edited time and status out.
interface time_set_editor_if
    import alarm_clk_pkg::*;
;
    logic  sel_pulse;
    logic  inc_pulse;
    logic  dec_pulse;
    logic  cancel_pulse;
    bcd2_t cur_hh_bcd;
    bcd2_t cur_mm_bcd;
    bcd2_t set_hh_bcd;
    bcd2_t set_mm_bcd;
    logic  editing;
    logic  field_hh;
    logic  commit;

    modport master (
        output sel_pulse, inc_pulse, dec_pulse, cancel_pulse, cur_hh_bcd, cur_mm_bcd,
        input  set_hh_bcd, set_mm_bcd, editing, field_hh, commit
    );

    modport slave (
        input  sel_pulse, inc_pulse, dec_pulse, cancel_pulse, cur_hh_bcd, cur_mm_bcd,
        output set_hh_bcd, set_mm_bcd, editing, field_hh, commit
    );
endinterface

// File: rtl/bcd_wrap_counter.sv
// Two-digit BCD up/down counter wrapping between 0 and MAX, with parallel load.
module bcd_wrap_counter
    import alarm_clk_pkg::*;
#(
    parameter int MAX = HH_MAX_DEF
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  bcd2_t load_val,
    input  logic  inc,
    input  logic  dec,
    output bcd2_t value
);
    localparam bcd2_t MAX_BCD = {4'(MAX / 10), 4'(MAX % 10)};

    logic [3:0] tens;
    logic [3:0] ones;
    logic       in_range;
    bcd2_t      inc_next;
    bcd2_t      dec_next;

    assign tens     = value[7:4];
    assign ones     = value[3:0];
    // Valid BCD compares correctly as a plain byte, so MAX_BCD bounds it directly.
    assign in_range = (tens <= 4'd9) && (ones <= 4'd9) && (value <= MAX_BCD);

    always_comb begin
        inc_next = 8'h00;
        dec_next = MAX_BCD;
        if (in_range && value != MAX_BCD) begin
            if (ones == 4'd9) inc_next = {tens + 4'd1, 4'd0};
            else              inc_next = {tens, ones + 4'd1};
        end
        if (in_range && value != 8'h00) begin
            if (ones == 4'd0) dec_next = {tens - 4'd1, 4'd9};
            else              dec_next = {tens, ones - 4'd1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             value <= 8'h00;
        else if (load)         value <= load_val;
        else if (inc && !dec)  value <= inc_next;
        else if (dec && !inc)  value <= dec_next;
    end
endmodule

// File: rtl/time_set_editor.sv
// HH:MM edit controller: sel enters/advances, inc/dec adjust, cancel restores.
// Optional inactivity timeout enabled by defining EDIT_TIMEOUT_EN.
module time_set_editor
    import alarm_clk_pkg::*;
#(
    parameter int HH_MAX = HH_MAX_DEF,
    parameter int MM_MAX = MM_MAX_DEF
`ifdef EDIT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1_000_000_000
`endif
) (
    input  logic              clk,
    input  logic              reset,
    time_set_editor_if.slave  bus
);
    logic        sel_reg, inc_reg, dec_reg, cancel_reg;
    bcd2_t       cur_reg    [2];
    bcd2_t       shadow_reg [2];
    bcd2_t       field_val  [2];
    logic        fld_load   [2];
    bcd2_t       fld_load_val [2];
    logic        fld_inc    [2];
    logic        fld_dec    [2];
    edit_state_t state_reg;
    logic        editing_reg, field_hh_reg, commit_reg;
    logic        in_edit, abort, enter, step_ok, timeout_hit;

    // Pulses and the current time are registered once before the FSM sees them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_reg    <= 1'b0;
            inc_reg    <= 1'b0;
            dec_reg    <= 1'b0;
            cancel_reg <= 1'b0;
            cur_reg[0] <= 8'h00;
            cur_reg[1] <= 8'h00;
        end else begin
            sel_reg    <= bus.sel_pulse;
            inc_reg    <= bus.inc_pulse;
            dec_reg    <= bus.dec_pulse;
            cancel_reg <= bus.cancel_pulse;
            cur_reg[0] <= bus.cur_hh_bcd;
            cur_reg[1] <= bus.cur_mm_bcd;
        end
    end

    assign in_edit = (state_reg == EDIT_HH) || (state_reg == EDIT_MM);
    assign abort   = in_edit && (cancel_reg || timeout_hit);
    assign enter   = (state_reg == IDLE) && sel_reg;
    assign step_ok = !abort && !sel_reg && (inc_reg ^ dec_reg);

`ifdef EDIT_TIMEOUT_EN
    logic [29:0] idle_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idle_cnt_reg <= '0;
        else if (!in_edit || sel_reg || inc_reg || dec_reg)
            idle_cnt_reg <= '0;
        else
            idle_cnt_reg <= idle_cnt_reg + 30'd1;
    end

    assign timeout_hit = in_edit && (idle_cnt_reg == 30'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Field 0 is hours, field 1 is minutes.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_field
            localparam edit_state_t FIELD_STATE = (gi == 0) ? EDIT_HH : EDIT_MM;

            assign fld_load[gi]     = enter || abort;
            assign fld_load_val[gi] = enter ? cur_reg[gi] : shadow_reg[gi];
            assign fld_inc[gi]      = step_ok && inc_reg && (state_reg == FIELD_STATE);
            assign fld_dec[gi]      = step_ok && dec_reg && (state_reg == FIELD_STATE);

            bcd_wrap_counter #(
                .MAX ((gi == 0) ? HH_MAX : MM_MAX)
            ) u_cnt (
                .clk      (clk),
                .reset    (reset),
                .load     (fld_load[gi]),
                .load_val (fld_load_val[gi]),
                .inc      (fld_inc[gi]),
                .dec      (fld_dec[gi]),
                .value    (field_val[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            shadow_reg[0] <= 8'h00;
            shadow_reg[1] <= 8'h00;
            editing_reg   <= 1'b0;
            field_hh_reg  <= 1'b0;
            commit_reg    <= 1'b0;
        end else begin
            commit_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (sel_reg) begin
                        state_reg     <= EDIT_HH;
                        shadow_reg[0] <= cur_reg[0];
                        shadow_reg[1] <= cur_reg[1];
                        editing_reg   <= 1'b1;
                        field_hh_reg  <= 1'b1;
                    end
                end
                EDIT_HH: begin
                    if (abort) begin
                        state_reg    <= IDLE;
                        editing_reg  <= 1'b0;
                        field_hh_reg <= 1'b0;
                    end else if (sel_reg) begin
                        state_reg    <= EDIT_MM;
                        field_hh_reg <= 1'b0;
                    end
                end
                EDIT_MM: begin
                    if (abort) begin
                        state_reg   <= IDLE;
                        editing_reg <= 1'b0;
                    end else if (sel_reg) begin
                        state_reg   <= COMMIT;
                        editing_reg <= 1'b0;
                        commit_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.set_hh_bcd = field_val[0];
    assign bus.set_mm_bcd = field_val[1];
    assign bus.editing    = editing_reg;
    assign bus.field_hh   = field_hh_reg;
    assign bus.commit     = commit_reg;
endmodule

// File: tb/tb_time_set_editor.sv
// Directed bench for time_set_editor; timeout scenario runs only with EDIT_TIMEOUT_EN.
module tb_time_set_editor;
    import alarm_clk_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   commit_seen = 0;
    int   commit_base;

    time_set_editor_if bus();

`ifdef EDIT_TIMEOUT_EN
    time_set_editor #(.TIMEOUT_CYCLES(16)) dut (
`else
    time_set_editor dut (
`endif
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.commit === 1'b1) commit_seen++;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic i, input logic d, input logic c);
        bus.sel_pulse    = s;
        bus.inc_pulse    = i;
        bus.dec_pulse    = d;
        bus.cancel_pulse = c;
    endtask

    task automatic set_cur(input bcd2_t hh, input bcd2_t mm);
        bus.cur_hh_bcd = hh;
        bus.cur_mm_bcd = mm;
    endtask

    // One-cycle pulse, then wait until it is visible on the outputs.
    task automatic step(input logic s, input logic i, input logic d, input logic c);
        drive(s, i, d, c);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic burst(input logic i, input logic d, input int n);
        drive(1'b0, i, d, 1'b0);
        repeat (n) tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        set_cur(8'h12, 8'h34);
        repeat (2) tick();
        chk("rst_hh", bus.set_hh_bcd, 8'h00);
        chk("rst_editing", {7'd0, bus.editing}, 8'h00);
        reset = 1'b0;
        tick();

        // 1: reset mid-edit, then entry latency
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_hh", bus.set_hh_bcd, 8'h13);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_hh", bus.set_hh_bcd, 8'h00);
        chk("async_rst_mm", bus.set_mm_bcd, 8'h00);
        chk("async_rst_editing", {7'd0, bus.editing}, 8'h00);
        chk("async_rst_commit", {7'd0, bus.commit}, 8'h00);
        tick();
        reset = 1'b0;
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("latency_field_hh_n", {7'd0, bus.field_hh}, 8'h00);
        tick();
        chk("entry_hh", bus.set_hh_bcd, 8'h12);
        chk("entry_mm", bus.set_mm_bcd, 8'h34);
        chk("entry_field_hh", {7'd0, bus.field_hh}, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // 2: wrap and digit boundaries
        set_cur(8'h23, 8'h59);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("hh_23_inc", bus.set_hh_bcd, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("hh_00_dec", bus.set_hh_bcd, 8'h23);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("mm_59_inc", bus.set_mm_bcd, 8'h00);
        burst(1'b1, 1'b0, 9);
        chk("mm_to_09", bus.set_mm_bcd, 8'h09);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("mm_09_inc", bus.set_mm_bcd, 8'h10);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("mm_10_dec", bus.set_mm_bcd, 8'h09);
        commit_base = commit_seen;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("cancel_hh", bus.set_hh_bcd, 8'h23);
        chk("cancel_mm", bus.set_mm_bcd, 8'h59);
        chk("cancel_editing", {7'd0, bus.editing}, 8'h00);

        // 3: full sequence with commit
        set_cur(8'h07, 8'h45);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        burst(1'b1, 1'b0, 3);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("seq_field_hh", {7'd0, bus.field_hh}, 8'h00);
        burst(1'b0, 1'b1, 2);
        commit_base = commit_seen;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("seq_commit", {7'd0, bus.commit}, 8'h01);
        chk("seq_hh", bus.set_hh_bcd, 8'h10);
        chk("seq_mm", bus.set_mm_bcd, 8'h43);
        tick();
        chk("seq_commit_drop", {7'd0, bus.commit}, 8'h00);
        repeat (3) tick();
        chk("seq_commit_cycles", 8'(commit_seen - commit_base), 8'd1);
        chk("seq_hold_hh", bus.set_hh_bcd, 8'h10);
        chk("seq_idle_editing", {7'd0, bus.editing}, 8'h00);

        // 4: simultaneous events
        set_cur(8'h05, 8'h20);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("incdec_hh", bus.set_hh_bcd, 8'h05);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("selinc_hh", bus.set_hh_bcd, 8'h05);
        chk("selinc_field_hh", {7'd0, bus.field_hh}, 8'h00);
        chk("selinc_editing", {7'd0, bus.editing}, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_cancel_hh", bus.set_hh_bcd, 8'h06);
        commit_base = commit_seen;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("cancelsel_hh", bus.set_hh_bcd, 8'h05);
        chk("cancelsel_editing", {7'd0, bus.editing}, 8'h00);
        repeat (2) tick();
        chk("cancelsel_no_commit", 8'(commit_seen - commit_base), 8'd0);

        // 5: thirty back-to-back increments in minutes
        set_cur(8'h00, 8'h40);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        burst(1'b1, 1'b0, 30);
        chk("burst30_mm", bus.set_mm_bcd, 8'h10);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // out-of-range loads
        set_cur(8'h3A, 8'h75);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("bad_load_hh", bus.set_hh_bcd, 8'h3A);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("bad_inc_hh", bus.set_hh_bcd, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("bad_dec_mm", bus.set_mm_bcd, 8'h59);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bad_restore_mm", bus.set_mm_bcd, 8'h75);

`ifdef EDIT_TIMEOUT_EN
        // 6: inactivity timeout with TIMEOUT_CYCLES=16
        commit_base = commit_seen;
        set_cur(8'h08, 8'h15);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (15) tick();
        chk("to_before", {7'd0, bus.editing}, 8'h01);
        tick();
        chk("to_expired", {7'd0, bus.editing}, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (9) tick();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("to_inc_hh", bus.set_hh_bcd, 8'h09);
        repeat (14) tick();
        chk("to_restart", {7'd0, bus.editing}, 8'h01);
        repeat (2) tick();
        chk("to_restart_expired", {7'd0, bus.editing}, 8'h00);
        chk("to_restore_hh", bus.set_hh_bcd, 8'h08);
        chk("to_no_commit", 8'(commit_seen - commit_base), 8'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
